// File: rtl/comparator_4bit.sv
// Registered magnitude comparator: one-hot eq/gt/lt result one cycle after a
// valid sample, plus saturating per-outcome event counters.
module comparator_4bit #(
  parameter int WIDTH     = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  input  logic                 cnt_clr,
  output logic                 out_valid,
  output logic                 a_Eq_b,
  output logic                 a_grt_b,
  output logic                 a_less_b,
  output logic [CNT_WIDTH-1:0] eq_count,
  output logic [CNT_WIDTH-1:0] grt_count,
  output logic [CNT_WIDTH-1:0] less_count
);

  // Handshake: a sample is taken on every edge with in_valid=1 (no ready,
  // no backpressure); out_valid is high for exactly the cycle after it.
  localparam logic [CNT_WIDTH-1:0] CntMax = '1;
  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

  logic                 valid_q, valid_d;
  logic                 eq_q, eq_d;
  logic                 gt_q, gt_d;
  logic                 lt_q, lt_d;
  logic [CNT_WIDTH-1:0] eq_cnt_q, eq_cnt_d;
  logic [CNT_WIDTH-1:0] gt_cnt_q, gt_cnt_d;
  logic [CNT_WIDTH-1:0] lt_cnt_q, lt_cnt_d;

  logic cmp_eq, cmp_gt, cmp_lt;

  always_comb begin
    cmp_eq = (a == b);
    if (signed_mode) begin
      cmp_gt = ($signed(a) > $signed(b));
    end else begin
      cmp_gt = (a > b);
    end
    cmp_lt = !cmp_eq && !cmp_gt;
  end

  always_comb begin
    valid_d  = in_valid;
    eq_d     = eq_q;
    gt_d     = gt_q;
    lt_d     = lt_q;
    eq_cnt_d = eq_cnt_q;
    gt_cnt_d = gt_cnt_q;
    lt_cnt_d = lt_cnt_q;

    // Flags hold their last value through idle cycles.
    if (in_valid) begin
      eq_d = cmp_eq;
      gt_d = cmp_gt;
      lt_d = cmp_lt;
    end

    // Clear takes priority over counting a simultaneous sample.
    if (cnt_clr) begin
      eq_cnt_d = '0;
      gt_cnt_d = '0;
      lt_cnt_d = '0;
    end else if (in_valid) begin
      if (cmp_eq && eq_cnt_q != CntMax) eq_cnt_d = eq_cnt_q + CntOne;
      if (cmp_gt && gt_cnt_q != CntMax) gt_cnt_d = gt_cnt_q + CntOne;
      if (cmp_lt && lt_cnt_q != CntMax) lt_cnt_d = lt_cnt_q + CntOne;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      eq_q     <= 1'b0;
      gt_q     <= 1'b0;
      lt_q     <= 1'b0;
      eq_cnt_q <= '0;
      gt_cnt_q <= '0;
      lt_cnt_q <= '0;
    end else begin
      valid_q  <= valid_d;
      eq_q     <= eq_d;
      gt_q     <= gt_d;
      lt_q     <= lt_d;
      eq_cnt_q <= eq_cnt_d;
      gt_cnt_q <= gt_cnt_d;
      lt_cnt_q <= lt_cnt_d;
    end
  end

  assign out_valid  = valid_q;
  assign a_Eq_b     = eq_q;
  assign a_grt_b    = gt_q;
  assign a_less_b   = lt_q;
  assign eq_count   = eq_cnt_q;
  assign grt_count  = gt_cnt_q;
  assign less_count = lt_cnt_q;

endmodule

// File: tb/tb_comparator_4bit.sv
// Bench for comparator_4bit: directed and random compares checked against an
// integer-arithmetic reference model with saturating outcome counters.
module tb_comparator_4bit;

  localparam int W       = 4;
  localparam int CW      = 8;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          run_clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          signed_mode = 1'b0;
  logic          cnt_clr = 1'b0;
  logic          out_valid;
  logic          a_Eq_b, a_grt_b, a_less_b;
  logic [CW-1:0] eq_count, grt_count, less_count;

  comparator_4bit #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .a          (a),
    .b          (b),
    .signed_mode(signed_mode),
    .cnt_clr    (cnt_clr),
    .out_valid  (out_valid),
    .a_Eq_b     (a_Eq_b),
    .a_grt_b    (a_grt_b),
    .a_less_b   (a_less_b),
    .eq_count   (eq_count),
    .grt_count  (grt_count),
    .less_count (less_count)
  );

  // Clock generator; held low until run_clk so reset can be observed without edges.
  always begin
    #5;
    if (run_clk) clk = ~clk;
  end

  int tests = 0;
  int fails = 0;

  // Model state: expected result queue, held flags {eq,gt,lt}, counters.
  logic [2:0] exp_q[$];
  logic       m_valid = 1'b0;
  logic [2:0] m_flags = 3'b000;
  int         m_eq = 0, m_gt = 0, m_lt = 0;

  function automatic logic [2:0] ref_outcome(input logic [W-1:0] av, input logic [W-1:0] bv,
                                              input logic sm);
    int x, y;
    x = int'(av);
    y = int'(bv);
    if (sm && x >= (1 << (W - 1))) x = x - (1 << W);
    if (sm && y >= (1 << (W - 1))) y = y - (1 << W);
    if (x == y) return 3'b100;
    if (x > y)  return 3'b010;
    return 3'b001;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
    check({tag, ".flags"}, 32'({a_Eq_b, a_grt_b, a_less_b}), 32'(m_flags));
    check({tag, ".eq_count"}, 32'(eq_count), 32'(m_eq));
    check({tag, ".grt_count"}, 32'(grt_count), 32'(m_gt));
    check({tag, ".less_count"}, 32'(less_count), 32'(m_lt));
    if (out_valid === 1'b1)
      check({tag, ".onehot"}, 32'($countones({a_Eq_b, a_grt_b, a_less_b})), 32'd1);
  endtask

  function automatic int sat_inc(input int c);
    return (c < CNT_MAX) ? c + 1 : c;
  endfunction

  // Called at a negedge: drive one cycle of inputs, step model, check after the edge.
  task automatic cycle(input string tag, input logic v, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic sm, input logic clr);
    in_valid    = v;
    a           = av;
    b           = bv;
    signed_mode = sm;
    cnt_clr     = clr;
    if (v) exp_q.push_back(ref_outcome(av, bv, sm));
    @(negedge clk);
    m_valid = v;
    if (v) m_flags = exp_q.pop_front();
    if (clr) begin
      m_eq = 0; m_gt = 0; m_lt = 0;
    end else if (v) begin
      if (m_flags == 3'b100) m_eq = sat_inc(m_eq);
      if (m_flags == 3'b010) m_gt = sat_inc(m_gt);
      if (m_flags == 3'b001) m_lt = sat_inc(m_lt);
    end
    check_all(tag);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_valid = 1'b0;
    m_flags = 3'b000;
    m_eq = 0; m_gt = 0; m_lt = 0;
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rs;

    // Reset with no clock running.
    #1 rst = 1'b1;
    #2;
    model_reset();
    check_all("reset_noclk");
    run_clk = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cycle("idle_after_reset", 1'b0, '0, '0, 1'b0, 1'b0);

    // Unsigned directed.
    cycle("u_eq", 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0);
    check("u_eq.const", 32'(a_Eq_b), 32'd1);
    cycle("u_gt", 1'b1, 4'b1010, 4'b0011, 1'b0, 1'b0);
    check("u_gt.const", 32'(a_grt_b), 32'd1);
    cycle("u_lt", 1'b1, 4'b0001, 4'b1111, 1'b0, 1'b0);
    check("u_lt.const", 32'(a_less_b), 32'd1);

    // Signed directed, then the same operands unsigned.
    cycle("s_lt", 1'b1, 4'b1111, 4'b0001, 1'b1, 1'b0);
    check("s_lt.const", 32'(a_less_b), 32'd1);
    cycle("s_gt", 1'b1, 4'b0111, 4'b1000, 1'b1, 1'b0);
    check("s_gt.const", 32'(a_grt_b), 32'd1);
    cycle("u_gt2", 1'b1, 4'b1111, 4'b0001, 1'b0, 1'b0);
    check("u_gt2.const", 32'(a_grt_b), 32'd1);

    // Streaming random pairs, then idle to check hold.
    for (int i = 0; i < 25; i++) begin
      ra = W'($urandom_range(0, (1 << W) - 1));
      rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom_range(0, (1 << W) - 1));
      rs = 1'($urandom_range(0, 1));
      cycle("stream", 1'b1, ra, rb, rs, 1'b0);
    end
    cycle("hold", 1'b0, '0, '0, 1'b0, 1'b0);
    check("hold.out_valid0", 32'(out_valid), 32'd0);

    // Counter totals after a clear.
    cycle("clr", 1'b0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cycle("cnt_eq", 1'b1, 4'(i), 4'(i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle("cnt_gt", 1'b1, 4'(i + 5), 4'(i), 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) cycle("cnt_lt", 1'b1, 4'(i), 4'(i + 9), 1'b0, 1'b0);
    check("cnt.eq5", 32'(eq_count), 32'd5);
    check("cnt.gt3", 32'(grt_count), 32'd3);
    check("cnt.lt2", 32'(less_count), 32'd2);

    // Clear wins over a simultaneous valid equal compare.
    cycle("clr_valid", 1'b1, 4'b0110, 4'b0110, 1'b0, 1'b1);
    check("clr_valid.eq_count0", 32'(eq_count), 32'd0);
    check("clr_valid.a_Eq_b", 32'(a_Eq_b), 32'd1);

    // Saturation.
    for (int i = 0; i < 300; i++) cycle("sat", 1'b1, 4'b0011, 4'b0011, 1'b0, 1'b0);
    check("sat.eq255", 32'(eq_count), 32'd255);

    // Asynchronous reset between edges while a valid sample is in flight.
    cycle("pre_rst", 1'b1, 4'b1000, 4'b0001, 1'b0, 1'b0);
    in_valid = 1'b1;
    a = 4'b0010;
    b = 4'b0010;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    check_all("async_rst_held");
    rst = 1'b0;
    cycle("post_rst_idle", 1'b0, '0, '0, 1'b0, 1'b0);
    cycle("post_rst_first", 1'b1, 4'b0101, 4'b1001, 1'b1, 1'b0);
    check("post_rst_first.gt", 32'(a_grt_b), 32'd1);
    check("post_rst_first.gt_count", 32'(grt_count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
